execute_div_writeback: RTL and testbench
========================================

Name: execute_div_writeback

Overview:
- Downstream consumer of the divider: follows a DIV/IDIV/AAM from execute entry to completion.
- Latches the divider's quotient/remainder and formats the architectural register images (AL/AH, AX/DX, EAX/EDX) plus AAM flags.
- Raises #DE on divider exception.
- Presents exactly one result or exception to the writeback stage under a valid/ready handshake.

Parameters:
- DE_VECTOR, 8'd0, exception vector reported on divide error.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- exe_reset  in  1  pipeline flush; highest priority after rst_n
- exe_valid  in  1  instruction present in execute
- exe_cmd  in  7  command; divide-class = CMD_DIV, CMD_IDIV, CMD_AAM
- exe_is_8bit  in  1  byte operand size
- exe_operand_16bit  in  1  word operand size
- exe_operand_32bit  in  1  dword operand size
- eax  in  32  current EAX (upper bits preserved)
- edx  in  32  current EDX (upper bits preserved)
- div_busy  in  1  divider busy
- exe_div_exception  in  1  divider exception (zero, min-int, overflow)
- div_result_quotient  in  32  divider quotient
- div_result_remainder  in  32  divider remainder
- wr_ready  in  1  writeback accepts
- wb_valid  out  1  result or exception offered
- wb_eax  out  32  new EAX
- wb_edx  out  32  new EDX
- wb_edx_write  out  1  EDX to be written
- wb_flags_write  out  1  SF/ZF/PF to be written (AAM only)
- wb_sf  out  1  sign flag
- wb_zf  out  1  zero flag
- wb_pf  out  1  parity flag
- wb_exc  out  1  entry is an exception
- wb_exc_vector  out  8  exception vector
- div_done  out  1  one-cycle pulse on handshake completion; execute retires instruction

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE.
  - All outputs and latched registers 0.
  - exe_reset has identical effect from any state, including mid-BUSY or while wb_valid is held; the offered entry is dropped and no div_done is issued.
- States:
  - IDLE→BUSY: exe_valid && divide-class cmd. On entry, latch cmd, size, eax, edx.
  - BUSY→EXC: exe_div_exception=1, sampled every BUSY cycle including the first. Exception takes priority over a simultaneous div_busy=0.
  - BUSY→RESULT: div_busy=0 && exe_div_exception=0. Register the formatted result on this edge; wb_valid=1 the next cycle.
  - RESULT/EXC: hold wb_valid and all wb_* stable while wr_ready=0. The cycle wr_ready=1 with wb_valid=1 is the transfer. Next edge: state=IDLE, wb_valid=0, div_done=1 for exactly one cycle.
  - While wb_valid=1, exe_valid/cmd changes are ignored; no new capture occurs until IDLE.
- Formatting, DIV/IDIV:
  - 8-bit: wb_eax={eax[31:16],rem[7:0],quot[7:0]}; wb_edx_write=0.
  - 16-bit: wb_eax={eax[31:16],quot[15:0]}; wb_edx={edx[31:16],rem[15:0]}; wb_edx_write=1.
  - 32-bit: wb_eax=quot; wb_edx=rem; wb_edx_write=1.
- Formatting, AAM: wb_eax={eax[31:16],quot[7:0],rem[7:0]}; wb_edx_write=0; wb_flags_write=1.
  - wb_sf=rem[7]
  - wb_zf=(rem[7:0]==0)
  - wb_pf=~^rem[7:0]
- wb_flags_write=0 and flag outputs 0 for DIV/IDIV.
- EXC: wb_exc=1, wb_exc_vector=DE_VECTOR, wb_edx_write=0, wb_flags_write=0, wb_eax=latched eax (registers unmodified).
- Latency: first wb_valid cycle is exactly 1 cycle after the edge on which div_busy=0 is sampled. Minimum IDLE→div_done is 3 cycles with wr_ready held 1.

Test Plan:
- DIV 8-bit, eax=0x12340064, src=7 (quot=0x0E, rem=0x02) → wb_eax=0x1234020E, wb_edx_write=0, div_done pulse after transfer.
- IDIV 32-bit, edx:eax=-100, src=7 (quot=0xFFFFFFF2, rem=0xFFFFFFFE) → wb_eax=0xFFFFFFF2, wb_edx=0xFFFFFFFE, wb_edx_write=1.
- AAM, AL=0x4F, base 10 (quot=7, rem=9) → wb_eax[15:0]=0x0709, wb_flags_write=1, sf=0, zf=0, pf=1.
- DIV 16-bit with exe_div_exception asserted in BUSY → wb_exc=1, vector 0x00, no register/flag write.
- wr_ready=0 for 3 cycles in RESULT → wb_* stable and single div_done pulse only after wr_ready=1.
- exe_reset asserted mid-BUSY, then exe_reset asserted with wb_valid=1 → IDLE next cycle, wb_valid=0, no div_done.

Source files
------------

// File: rtl/execute_div_writeback.sv
// Writeback side of the divider: tracks a DIV/IDIV/AAM from execute entry to retirement,
// formats the register images and flags, and offers one result or #DE under valid/ready.
module execute_div_writeback #(
  parameter logic [7:0] DE_VECTOR = 8'd0,
  parameter logic [6:0] CMD_DIV   = 7'd40,
  parameter logic [6:0] CMD_IDIV  = 7'd41,
  parameter logic [6:0] CMD_AAM   = 7'd42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_reset,
  input  logic        exe_valid,
  input  logic [6:0]  exe_cmd,
  input  logic        exe_is_8bit,
  input  logic        exe_operand_16bit,
  input  logic        exe_operand_32bit,
  input  logic [31:0] eax,
  input  logic [31:0] edx,
  input  logic        div_busy,
  input  logic        exe_div_exception,
  input  logic [31:0] div_result_quotient,
  input  logic [31:0] div_result_remainder,
  input  logic        wr_ready,
  output logic        wb_valid,
  output logic [31:0] wb_eax,
  output logic [31:0] wb_edx,
  output logic        wb_edx_write,
  output logic        wb_flags_write,
  output logic        wb_sf,
  output logic        wb_zf,
  output logic        wb_pf,
  output logic        wb_exc,
  output logic [7:0]  wb_exc_vector,
  output logic        div_done
);

  typedef enum logic [1:0] {IDLE, BUSY, RESULT, EXC} state_t;

  localparam logic [1:0] SZ8  = 2'd0;
  localparam logic [1:0] SZ16 = 2'd1;
  localparam logic [1:0] SZ32 = 2'd2;

  state_t      state, state_next;
  logic [6:0]  cmd_q;
  logic [1:0]  size_q;
  logic [31:0] eax_q, edx_q;
  logic        is_div_cmd, start;
  logic [1:0]  size_in;

  logic [31:0] fmt_eax, fmt_edx;
  logic        fmt_edx_write, fmt_flags_write, fmt_sf, fmt_zf, fmt_pf;

  assign is_div_cmd = (exe_cmd == CMD_DIV) || (exe_cmd == CMD_IDIV) || (exe_cmd == CMD_AAM);
  // The retiring instruction is still in execute during the div_done cycle; don't re-capture it.
  assign start      = exe_valid && is_div_cmd && !div_done;
  assign size_in    = exe_is_8bit ? SZ8 : (exe_operand_16bit ? SZ16 : SZ32);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY: begin
        if (exe_div_exception) state_next = EXC;
        else if (!div_busy)    state_next = RESULT;
      end
      RESULT,
      EXC:     if (wr_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fmt_eax         = eax_q;
    fmt_edx         = edx_q;
    fmt_edx_write   = 1'b0;
    fmt_flags_write = 1'b0;
    fmt_sf          = 1'b0;
    fmt_zf          = 1'b0;
    fmt_pf          = 1'b0;
    if (cmd_q == CMD_AAM) begin
      fmt_eax         = {eax_q[31:16], div_result_quotient[7:0], div_result_remainder[7:0]};
      fmt_flags_write = 1'b1;
      fmt_sf          = div_result_remainder[7];
      fmt_zf          = (div_result_remainder[7:0] == 8'd0);
      fmt_pf          = ~^div_result_remainder[7:0];
    end else begin
      case (size_q)
        SZ8: fmt_eax = {eax_q[31:16], div_result_remainder[7:0], div_result_quotient[7:0]};
        SZ16: begin
          fmt_eax       = {eax_q[31:16], div_result_quotient[15:0]};
          fmt_edx       = {edx_q[31:16], div_result_remainder[15:0]};
          fmt_edx_write = 1'b1;
        end
        default: begin
          fmt_eax       = div_result_quotient;
          fmt_edx       = div_result_remainder;
          fmt_edx_write = 1'b1;
        end
      endcase
    end
  end

  // A flush behaves exactly like reset: the offered entry is discarded without div_done.
  always_ff @(posedge clk) begin
    if (!rst_n || exe_reset) begin
      state          <= IDLE;
      cmd_q          <= '0;
      size_q         <= '0;
      eax_q          <= '0;
      edx_q          <= '0;
      wb_valid       <= 1'b0;
      wb_eax         <= '0;
      wb_edx         <= '0;
      wb_edx_write   <= 1'b0;
      wb_flags_write <= 1'b0;
      wb_sf          <= 1'b0;
      wb_zf          <= 1'b0;
      wb_pf          <= 1'b0;
      wb_exc         <= 1'b0;
      wb_exc_vector  <= '0;
      div_done       <= 1'b0;
    end else begin
      state    <= state_next;
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cmd_q  <= exe_cmd;
            size_q <= size_in;
            eax_q  <= eax;
            edx_q  <= edx;
          end
        end
        BUSY: begin
          if (exe_div_exception) begin
            wb_valid       <= 1'b1;
            wb_exc         <= 1'b1;
            wb_exc_vector  <= DE_VECTOR;
            wb_eax         <= eax_q;
            wb_edx         <= edx_q;
            wb_edx_write   <= 1'b0;
            wb_flags_write <= 1'b0;
            wb_sf          <= 1'b0;
            wb_zf          <= 1'b0;
            wb_pf          <= 1'b0;
          end else if (!div_busy) begin
            wb_valid       <= 1'b1;
            wb_exc         <= 1'b0;
            wb_exc_vector  <= '0;
            wb_eax         <= fmt_eax;
            wb_edx         <= fmt_edx;
            wb_edx_write   <= fmt_edx_write;
            wb_flags_write <= fmt_flags_write;
            wb_sf          <= fmt_sf;
            wb_zf          <= fmt_zf;
            wb_pf          <= fmt_pf;
          end
        end
        RESULT,
        EXC: begin
          if (wr_ready) begin
            wb_valid       <= 1'b0;
            wb_exc         <= 1'b0;
            wb_exc_vector  <= '0;
            wb_eax         <= '0;
            wb_edx         <= '0;
            wb_edx_write   <= 1'b0;
            wb_flags_write <= 1'b0;
            wb_sf          <= 1'b0;
            wb_zf          <= 1'b0;
            wb_pf          <= 1'b0;
            div_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_div_writeback.sv
// Directed bench for execute_div_writeback: vector table for the formatting paths plus
// hand-written sequences for backpressure, flush and non-divide commands.
module tb_execute_div_writeback;

  localparam logic [6:0] CMD_DIV  = 7'd40;
  localparam logic [6:0] CMD_IDIV = 7'd41;
  localparam logic [6:0] CMD_AAM  = 7'd42;

  logic        clk = 1'b0;
  logic        rst_n, exe_reset, exe_valid;
  logic [6:0]  exe_cmd;
  logic        exe_is_8bit, exe_operand_16bit, exe_operand_32bit;
  logic [31:0] eax, edx;
  logic        div_busy, exe_div_exception;
  logic [31:0] div_result_quotient, div_result_remainder;
  logic        wr_ready;
  logic        wb_valid;
  logic [31:0] wb_eax, wb_edx;
  logic        wb_edx_write, wb_flags_write, wb_sf, wb_zf, wb_pf, wb_exc;
  logic [7:0]  wb_exc_vector;
  logic        div_done;

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  execute_div_writeback #(
    .DE_VECTOR(8'd0), .CMD_DIV(CMD_DIV), .CMD_IDIV(CMD_IDIV), .CMD_AAM(CMD_AAM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset), .exe_valid(exe_valid),
    .exe_cmd(exe_cmd), .exe_is_8bit(exe_is_8bit), .exe_operand_16bit(exe_operand_16bit),
    .exe_operand_32bit(exe_operand_32bit), .eax(eax), .edx(edx), .div_busy(div_busy),
    .exe_div_exception(exe_div_exception), .div_result_quotient(div_result_quotient),
    .div_result_remainder(div_result_remainder), .wr_ready(wr_ready), .wb_valid(wb_valid),
    .wb_eax(wb_eax), .wb_edx(wb_edx), .wb_edx_write(wb_edx_write),
    .wb_flags_write(wb_flags_write), .wb_sf(wb_sf), .wb_zf(wb_zf), .wb_pf(wb_pf),
    .wb_exc(wb_exc), .wb_exc_vector(wb_exc_vector), .div_done(div_done)
  );

  typedef struct {
    logic [6:0]  cmd;
    logic [1:0]  size;
    logic [31:0] eax, edx, quot, rem;
    logic        exc;
    int          busy_cycles;
    logic [31:0] exp_eax, exp_edx;
    logic        exp_ew, exp_fw, exp_sf, exp_zf, exp_pf;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Issue one divide-class op, let the divider run busy_cycles, then finish with the result.
  task automatic startOp(input vec_t v);
    @(negedge clk);
    exe_valid = 1'b1;
    exe_cmd = v.cmd;
    exe_is_8bit = (v.size == 2'd0);
    exe_operand_16bit = (v.size == 2'd1);
    exe_operand_32bit = (v.size == 2'd2);
    eax = v.eax;
    edx = v.edx;
    @(negedge clk);
    exe_valid = 1'b0;
    exe_cmd = 7'd0;
    eax = 32'hDEADBEEF;
    edx = 32'hDEADBEEF;
    for (int k = 0; k < v.busy_cycles; k++) begin
      div_busy = 1'b1;
      @(negedge clk);
    end
    div_busy = 1'b0;
    exe_div_exception = v.exc;
    div_result_quotient = v.quot;
    div_result_remainder = v.rem;
    @(negedge clk);
    exe_div_exception = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    tag = $sformatf("v%0d", idx);
    wr_ready = 1'b1;
    startOp(v);
    checkOutput({tag, " wb_valid latency"}, 32'(wb_valid), 32'd1);
    checkOutput({tag, " wb_exc"}, 32'(wb_exc), 32'(v.exc));
    checkOutput({tag, " wb_exc_vector"}, 32'(wb_exc_vector), 32'd0);
    checkOutput({tag, " wb_eax"}, wb_eax, v.exp_eax);
    if (v.exp_ew) checkOutput({tag, " wb_edx"}, wb_edx, v.exp_edx);
    checkOutput({tag, " wb_edx_write"}, 32'(wb_edx_write), 32'(v.exp_ew));
    checkOutput({tag, " wb_flags_write"}, 32'(wb_flags_write), 32'(v.exp_fw));
    checkOutput({tag, " flags sf/zf/pf"}, {29'd0, wb_sf, wb_zf, wb_pf},
                {29'd0, v.exp_sf, v.exp_zf, v.exp_pf});
    @(negedge clk);
    checkOutput({tag, " div_done pulse"}, 32'(div_done), 32'd1);
    checkOutput({tag, " wb_valid dropped"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, " div_done cleared"}, 32'(div_done), 32'd0);
  endtask

  initial begin
    logic [31:0] held_eax, held_edx;
    vecs[0] = '{CMD_DIV,  2'd0, 32'h12340064, 32'hAAAA5555, 32'h0000000E, 32'h00000002, 1'b0, 1,
                32'h1234020E, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{CMD_IDIV, 2'd2, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 2,
                32'hFFFFFFF2, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{CMD_AAM,  2'd0, 32'h1234004F, 32'h0, 32'h00000007, 32'h00000009, 1'b0, 1,
                32'h12340709, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{CMD_DIV,  2'd1, 32'h11112222, 32'h33334444, 32'h00005555, 32'h00006666, 1'b1, 1,
                32'h11112222, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{CMD_DIV,  2'd1, 32'hABCD1234, 32'h56780001, 32'h00001111, 32'h00002222, 1'b0, 0,
                32'hABCD1111, 32'h56782222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{CMD_AAM,  2'd0, 32'hFFFF0014, 32'h0, 32'h00000002, 32'h00000000, 1'b0, 0,
                32'hFFFF0200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{CMD_AAM,  2'd0, 32'h00000085, 32'h0, 32'h00000000, 32'h00000085, 1'b0, 2,
                32'h00000085, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{CMD_IDIV, 2'd0, 32'h5555FF9C, 32'h0, 32'h000000F2, 32'h000000FE, 1'b0, 3,
                32'h5555FEF2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; exe_reset = 1'b0; exe_valid = 1'b0; exe_cmd = 7'd0;
    exe_is_8bit = 1'b0; exe_operand_16bit = 1'b0; exe_operand_32bit = 1'b0;
    eax = 32'h0; edx = 32'h0; div_busy = 1'b0; exe_div_exception = 1'b0;
    div_result_quotient = 32'h0; div_result_remainder = 32'h0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset wb_eax", wb_eax, 32'd0);
    checkOutput("reset div_done", 32'(div_done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // Non-divide command must not start anything.
    @(negedge clk);
    exe_valid = 1'b1; exe_cmd = 7'd3; div_busy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("non-div cmd ignored", 32'(wb_valid), 32'd0);
    exe_valid = 1'b0; exe_cmd = 7'd0;

    // Backpressure: result must hold for 3 stalled cycles, then retire once.
    wr_ready = 1'b0;
    startOp(vecs[1]);
    checkOutput("stall wb_valid", 32'(wb_valid), 32'd1);
    held_eax = wb_eax; held_edx = wb_edx;
    exe_valid = 1'b1; exe_cmd = CMD_DIV; exe_is_8bit = 1'b1; eax = 32'h01010101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d wb_valid", k), 32'(wb_valid), 32'd1);
      checkOutput($sformatf("stall%0d wb_eax", k), wb_eax, 32'hFFFFFFF2);
      checkOutput($sformatf("stall%0d wb_edx", k), wb_edx, 32'hFFFFFFFE);
      checkOutput($sformatf("stall%0d div_done", k), 32'(div_done), 32'd0);
    end
    checkOutput("stall eax stable", held_eax, wb_eax);
    exe_valid = 1'b0; exe_cmd = 7'd0;
    wr_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall div_done pulse", 32'(div_done), 32'd1);
    @(negedge clk);
    checkOutput("stall div_done single", 32'(div_done), 32'd0);
    checkOutput("stall no recapture", 32'(wb_valid), 32'd0);

    // Flush mid-BUSY: the op must vanish.
    @(negedge clk);
    exe_valid = 1'b1; exe_cmd = CMD_DIV; exe_is_8bit = 1'b1; eax = 32'h12340064;
    @(negedge clk);
    exe_valid = 1'b0; exe_cmd = 7'd0; div_busy = 1'b1;
    @(negedge clk);
    exe_reset = 1'b1;
    @(negedge clk);
    exe_reset = 1'b0; div_busy = 1'b0;
    checkOutput("flush busy wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("flush busy div_done", 32'(div_done), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("flush busy stays idle", 32'(wb_valid), 32'd0);

    // Flush while the result is offered: dropped, no div_done.
    wr_ready = 1'b0;
    startOp(vecs[4]);
    checkOutput("flush offer wb_valid before", 32'(wb_valid), 32'd1);
    exe_reset = 1'b1;
    @(negedge clk);
    exe_reset = 1'b0; wr_ready = 1'b1;
    checkOutput("flush offer wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("flush offer div_done", 32'(div_done), 32'd0);
    @(negedge clk);
    checkOutput("flush offer div_done later", 32'(div_done), 32'd0);
    checkOutput("flush offer wb_valid later", 32'(wb_valid), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
